// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered demultiplexer family.
// Default geometry is the classic 1-bit, 4-way demux.
package demux_pkg;

  localparam int DEMUX_DATA_W = 1;
  localparam int DEMUX_SEL_W  = 2;

  function automatic int n_out(input int sel_w);
    return 2**sel_w;
  endfunction

endpackage

// File: rtl/demux_onehot_dec.sv
// One-hot select decoder: onehot[k] is set exactly when sel == k.
// Purely combinational, no state, no flow control.
module demux_onehot_dec
  import demux_pkg::*;
#(
  parameter int SEL_W = DEMUX_SEL_W
) (
  input  logic [SEL_W-1:0]          sel,
  output logic [n_out(SEL_W)-1:0]   onehot
);

  for (genvar k = 0; k < n_out(SEL_W); k++) begin : g_dec
    assign onehot[k] = (sel == SEL_W'(k));
  end

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-N demux: lane sel gets in, all other lanes zero.
// Latency 1 cycle; accepts a new in/sel every cycle, no backpressure.
module demux_1to4
  import demux_pkg::*;
#(
  parameter  int DATA_W = DEMUX_DATA_W,
  parameter  int SEL_W  = DEMUX_SEL_W,
  localparam int N_OUT  = n_out(SEL_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in,
  input  logic [SEL_W-1:0]        sel,
  output logic [N_OUT*DATA_W-1:0] out
);

  logic [N_OUT-1:0]        onehot;
  logic [N_OUT*DATA_W-1:0] lane_d;

  demux_onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel    (sel),
    .onehot (onehot)
  );

  // Every lane is gated every cycle, so unselected lanes always load zero.
  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    assign lane_d[k*DATA_W +: DATA_W] = in & {DATA_W{onehot[k]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= lane_d;
    end
  end

endmodule

// File: tb/tb_demux_1to4.sv
// Scoreboard bench for demux_1to4: default 1x4 instance plus an 8-bit-lane instance.
module tb_demux_1to4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  in1;
  logic [1:0]  sel1;
  logic [3:0]  out1;
  logic [7:0]  in8;
  logic [1:0]  sel8;
  logic [31:0] out8;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [3:0]  e1;
    logic [31:0] e8;
  } exp_t;

  exp_t q[$];

  demux_1to4 u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in1),
    .sel   (sel1),
    .out   (out1)
  );

  demux_1to4 #(
    .DATA_W (8),
    .SEL_W  (2)
  ) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in8),
    .sel   (sel8),
    .out   (out8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the selected lane is the input shifted up by sel lane widths.
  function automatic logic [3:0] model1(input logic [0:0] d, input logic [1:0] s);
    return 4'(d) << s;
  endfunction

  function automatic logic [31:0] model8(input logic [7:0] d, input logic [1:0] s);
    return 32'(d) << (8 * int'(s));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one input pair to both DUTs; result is due one edge later.
  task automatic step(input logic [0:0] a, input logic [1:0] s,
                      input logic [7:0] b, input logic [1:0] t);
    exp_t e;
    in1  = a;
    sel1 = s;
    in8  = b;
    sel8 = t;
    e.due = cyc + 1;
    e.e1  = model1(a, s);
    e.e8  = model8(b, t);
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares registered outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   nz;
    if (!rst_n) begin
      chk("rst_out1", 32'(out1), 32'h0);
      chk("rst_out8", out8, 32'h0);
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("stale_entry", 32'(e.due), 32'(cyc));
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("out1", 32'(out1), 32'(e.e1));
        chk("out8", out8, e.e8);
      end
    end
    chk("onehot1", 32'($countones(out1) <= 1), 32'h1);
    nz = 0;
    for (int k = 0; k < 4; k++) if (out8[k*8 +: 8] != 8'h0) nz++;
    chk("onehot8", 32'(nz <= 1), 32'h1);
  end

  initial begin
    rst_n = 1'b0;
    in1   = 1'b1;
    sel1  = 2'b00;
    in8   = 8'hFF;
    sel8  = 2'b00;
    #1;
    chk("rst_async1", 32'(out1), 32'h0);
    chk("rst_async8", out8, 32'h0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Walk select with data 1.
    for (int s = 0; s < 4; s++) step(1'b1, 2'(s), 8'h5A, 2'(s));

    // Zero data on every lane.
    for (int s = 0; s < 4; s++) step(1'b0, 2'(s), 8'h00, 2'(3 - s));

    // Back-to-back alternation.
    step(1'b1, 2'b00, 8'h81, 2'b00);
    step(1'b1, 2'b11, 8'h81, 2'b11);
    step(1'b1, 2'b00, 8'h81, 2'b00);

    // Wide-lane sweep.
    step(1'b1, 2'b10, 8'hA5, 2'b10);
    step(1'b1, 2'b01, 8'hA5, 2'b01);

    // Latency: a change just after an edge must not show before the next edge.
    step(1'b1, 2'b00, 8'h3C, 2'b00);
    begin
      exp_t e;
      in1  = 1'b1;
      sel1 = 2'b11;
      in8  = 8'hC3;
      sel8 = 2'b11;
      e.due = cyc + 1;
      e.e1  = model1(1'b1, 2'b11);
      e.e8  = model8(8'hC3, 2'b11);
      q.push_back(e);
      #1;
      chk("latency1", 32'(out1), 32'h1);
      chk("latency8", out8, 32'h0000_003C);
      @(posedge clk);
      #2;
    end

    // Mid-cycle reset while lane 2 is driven; the pending load is discarded.
    step(1'b1, 2'b10, 8'h77, 2'b10);
    step(1'b1, 2'b10, 8'h77, 2'b10);
    #1;
    chk("pre_rst1", 32'(out1), 32'h4);
    chk("pre_rst8", out8, 32'h0077_0000);
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("mid_rst1", 32'(out1), 32'h0);
    chk("mid_rst8", out8, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 2'($urandom_range(3)), 8'($urandom), 2'($urandom_range(3)));
    end

    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1to4.md
# demux_1to4

Registered 1-to-4 demultiplexer: the data input is routed to exactly one of four output lanes, selected by a 2-bit select, and all other lanes are driven to zero. The module is a leaf utility for fanning a single source out to one of four destinations. Outputs are registered on one clock, giving a fixed one-cycle latency. Lane width and select width are parameterised; the defaults give the classic 1-bit, 4-way demux.

## Interface
Parameters:
- `DATA_W`, default 1: width of the data input and of each output lane.
- `SEL_W`, default 2: select width. Number of lanes `N_OUT = 2**SEL_W`, which is 4 by default.

Ports:
- `clk`, input, 1: rising-edge clock. Single clock domain.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in`, input, `DATA_W`: data to route.
- `sel`, input, `SEL_W`: lane select.
- `out`, output, `N_OUT*DATA_W`: lane k occupies bits `[k*DATA_W +: DATA_W]`. With defaults, `out[k]` is lane k.

## Operation
- At each rising `clk` edge with `rst_n` high, the register is loaded so that:
  - lane `sel` equals `in`;
  - every other lane equals 0.
- Lane 0 is the LSB lane. With defaults:
  - `sel=00` gives `out=000i`;
  - `sel=01` gives `out=00i0`;
  - `sel=10` gives `out=0i00`;
  - `sel=11` gives `out=i000`.
- When `in=0`, all of `out` is 0 regardless of `sel`.
- Outputs are driven only from the register; there is no combinational path from `in` or `sel` to `out`.
- The select decode is a one-hot decoder, `onehot[k] = (sel == k)`. Lane k register input is `in & {DATA_W{onehot[k]}}`.
- X or Z on `sel` is not required to be handled. The RTL must not infer latches, and every lane must be assigned on every cycle.

## Timing
- Reset:
  - Asserting `rst_n=0` forces `out` to all zeros immediately, with no wait for a clock edge.
  - `out` stays at zero for as long as `rst_n` is low.
- Release:
  - The first rising edge with `rst_n=1` loads from the current `in` and `sel`.
  - Deassertion is expected synchronous to `clk` at system level.
- Latency: exactly 1 cycle. `out` after edge n reflects `in` and `sel` sampled at edge n.
- Throughput: a new `in`/`sel` pair is accepted every cycle. Back-to-back select changes produce back-to-back lane changes, with no bubble and no overlap. At most one lane is ever non-zero.
- Reset mid-operation: an assertion between edges clears `out` at once. The value that was pending from before reset is discarded.
- Inputs must be stable around the rising edge, meeting the usual setup and hold requirements.

## Structure
- Shared package `demux_pkg`:
  - default constants `DEMUX_DATA_W=1` and `DEMUX_SEL_W=2`;
  - helper function `n_out(sel_w)` returning `2**sel_w`.
- Sub-module `demux_onehot_dec`:
  - parameter `SEL_W`;
  - input `sel`;
  - output `onehot[2**SEL_W-1:0]`;
  - purely combinational.
- Top `demux_1to4` instantiates the decoder, generates the per-lane AND gating, and holds the single async-reset output register bank.

## Test plan
- Reset: hold `rst_n=0` with `in=1`, `sel=00` and toggle `clk` → `out=0000` throughout. Assert `rst_n=0` mid-cycle while `out=0100` → `out=0000` before the next edge.
- Walk select with `in=1`, applying `sel=00,01,10,11` on consecutive cycles → `out=0001,0010,0100,1000`, each appearing one cycle after its input.
- Zero data: `in=0` with `sel=00..11` → `out=0000` on every cycle.
- Back-to-back alternation: `sel=00→11→00` with `in=1` on successive cycles → `out=0001,1000,0001`. Confirm no cycle has more than one bit set.
- Latency check: change `in`/`sel` just after an edge → `out` is unchanged until the next rising edge.
- Parameter sweep with `DATA_W=8`, `SEL_W=2`: `in=8'hA5`, `sel=10` → `out=32'h00A5_0000`. Then `sel=01` → `out=32'h0000_A500`.
